// File: rtl/svo_frame_switch_pkg.sv
// svo_frame_switch_pkg: arbiter state encoding shared by the frame switch and its bench.
package svo_frame_switch_pkg;
  typedef enum logic [1:0] {
    FSW_PASS     = 2'd0,
    FSW_WAIT_OLD = 2'd1,
    FSW_SEEK     = 2'd2
  } fsw_state_e;
endpackage

// File: rtl/svo_axis_reg.sv
// svo_axis_reg: one-stage AXI-stream register slice, full throughput, data and user packed together.
module svo_axis_reg #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = in_ready ? in_valid : valid_q;
    data_d   = (in_ready && in_valid) ? in_data : data_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/svo_frame_switch.sv
// svo_frame_switch: selects one of two SVO pixel streams, changing source only on SOF boundaries.
module svo_frame_switch
  import svo_frame_switch_pkg::*;
#(
  parameter int SVO_BITS_PER_PIXEL = 24,
  parameter bit DRAIN_IDLE         = 1'b1,
  parameter int FRAME_CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          sel,
  input  logic                          in0_axis_tvalid,
  output logic                          in0_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in0_axis_tdata,
  input  logic                          in0_axis_tuser,
  input  logic                          in1_axis_tvalid,
  output logic                          in1_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in1_axis_tdata,
  input  logic                          in1_axis_tuser,
  output logic                          out_axis_tvalid,
  input  logic                          out_axis_tready,
  output logic [SVO_BITS_PER_PIXEL-1:0] out_axis_tdata,
  output logic                          out_axis_tuser,
  output logic                          cur_sel,
  output logic                          busy,
  output logic [FRAME_CNT_W-1:0]        frame_count
);
  localparam int W = SVO_BITS_PER_PIXEL + 1;

  fsw_state_e             state_q, state_d;
  logic                   cur_sel_q, cur_sel_d, target_q, target_d;
  logic                   fresh_q, fresh_d, busy_q, busy_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic                   acc, head_valid, head_user, head_ready, slice_valid, sw, block;
  logic [W-1:0]           head_data;

  assign head_valid = cur_sel_q ? in1_axis_tvalid : in0_axis_tvalid;
  assign head_user  = cur_sel_q ? in1_axis_tuser : in0_axis_tuser;
  assign head_data  = cur_sel_q ? {in1_axis_tuser, in1_axis_tdata} : {in0_axis_tuser, in0_axis_tdata};

  // fresh_q: the SOF found by SEEK must be delivered before a new switch request is honoured
  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    target_d    = target_q;
    fresh_d     = fresh_q;
    head_ready  = 1'b0;
    slice_valid = 1'b0;
    sw          = (sel != cur_sel_q) && !fresh_q;
    block       = 1'b0;
    case (state_q)
      FSW_PASS: begin
        block       = sw && head_user;
        head_ready  = acc && !block;
        slice_valid = head_valid && !block;
        fresh_d     = fresh_q && !(head_valid && head_ready);
        if (sw) begin
          target_d = sel;
          state_d  = FSW_WAIT_OLD;
        end
      end
      FSW_WAIT_OLD: begin
        head_ready  = acc && !head_user;
        slice_valid = head_valid && !head_user;
        if (head_valid && head_user) begin
          cur_sel_d = target_q;
          state_d   = FSW_SEEK;
        end
      end
      default: begin
        head_ready = !head_user;
        if (head_valid && head_user) begin
          state_d = FSW_PASS;
          fresh_d = 1'b1;
        end
      end
    endcase
    busy_d        = state_d != FSW_PASS;
    frame_count_d = frame_count_q + FRAME_CNT_W'(out_axis_tvalid && out_axis_tready && out_axis_tuser);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= FSW_SEEK;
      cur_sel_q     <= 1'b0;
      target_q      <= 1'b0;
      fresh_q       <= 1'b0;
      busy_q        <= 1'b1;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_sel_q     <= cur_sel_d;
      target_q      <= target_d;
      fresh_q       <= fresh_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign in0_axis_tready = resetn && (cur_sel_q ? DRAIN_IDLE : head_ready);
  assign in1_axis_tready = resetn && (cur_sel_q ? head_ready : DRAIN_IDLE);
  assign cur_sel         = cur_sel_q;
  assign busy            = busy_q;
  assign frame_count     = frame_count_q;

  svo_axis_reg #(.W(W)) u_slice (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (slice_valid),
    .in_ready  (acc),
    .in_data   (head_data),
    .out_valid (out_axis_tvalid),
    .out_ready (out_axis_tready),
    .out_data  ({out_axis_tuser, out_axis_tdata})
  );
endmodule
